// File: rtl/ws2812_rx_if.sv
// WS2812 receiver bus: raw data line in, decoded words and frame events out.
interface ws2812_rx_if;
   logic        din_i;
   logic [23:0] data_o;
   logic        valid_o;
   logic        latch_o;
   logic [15:0] frame_len_o;
   logic        err_o;

   modport slave  (input din_i, output data_o, valid_o, latch_o, frame_len_o, err_o);
   modport master (output din_i, input data_o, valid_o, latch_o, frame_len_o, err_o);
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 one-wire stream decoder: measures high pulses, assembles 24-bit GRB
// words MSB first, reports latches (long low) and protocol errors.
module ws2812_rx #(
   parameter int unsigned ThreshCycles  = 24,
   parameter int unsigned MinHighCycles = 4,
   parameter int unsigned LatchCycles   = 2000
) (
   input  logic       clk_sys_i,
   input  logic       rst_sys_i,
   ws2812_rx_if.slave bus
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

   localparam logic [15:0] THRESH = 16'(ThreshCycles);
   localparam logic [15:0] MINHI  = 16'(MinHighCycles);
   localparam logic [15:0] LATCH  = 16'(LatchCycles);

   state_e      state_q, state_d;
   logic        sync_q, din_s_q, din_q;
   logic [15:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
   logic [4:0]  bitcnt_q, bitcnt_d;
   logic [15:0] pixcnt_q, pixcnt_d;
   logic [23:0] shreg_q, shreg_d;
   logic [23:0] data_q, data_d;
   logic [15:0] flen_q, flen_d;
   logic        valid_q, valid_d, latch_q, latch_d, err_q, err_d;

   logic        rise, fall, bit_v;
   logic [15:0] hcnt_inc, lcnt_inc, pixcnt_inc;

   assign rise       = din_s_q & ~din_q;
   assign fall       = ~din_s_q & din_q;
   assign bit_v      = (hcnt_q >= THRESH);
   assign hcnt_inc   = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
   assign lcnt_inc   = (lcnt_q == 16'hFFFF) ? lcnt_q : lcnt_q + 16'd1;
   assign pixcnt_inc = (pixcnt_q == 16'hFFFF) ? pixcnt_q : pixcnt_q + 16'd1;

   // Synchroniser, edge-detect delay and all decoder state
   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         sync_q   <= 1'b0;
         din_s_q  <= 1'b0;
         din_q    <= 1'b0;
         state_q  <= IDLE;
         hcnt_q   <= '0;
         lcnt_q   <= '0;
         bitcnt_q <= '0;
         pixcnt_q <= '0;
         shreg_q  <= '0;
         data_q   <= '0;
         flen_q   <= '0;
         valid_q  <= 1'b0;
         latch_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sync_q   <= bus.din_i;
         din_s_q  <= sync_q;
         din_q    <= din_s_q;
         state_q  <= state_d;
         hcnt_q   <= hcnt_d;
         lcnt_q   <= lcnt_d;
         bitcnt_q <= bitcnt_d;
         pixcnt_q <= pixcnt_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         flen_q   <= flen_d;
         valid_q  <= valid_d;
         latch_q  <= latch_d;
         err_q    <= err_d;
      end
   end

   // Pulse-measuring FSM; event outputs are registered one-cycle pulses
   always_comb begin
      state_d  = state_q;
      hcnt_d   = hcnt_q;
      lcnt_d   = lcnt_q;
      bitcnt_d = bitcnt_q;
      pixcnt_d = pixcnt_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      flen_d   = flen_q;
      valid_d  = 1'b0;
      latch_d  = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = HIGH;
               hcnt_d  = 16'd1;
            end
         end
         HIGH: begin
            if (fall) begin
               state_d = LOW;
               lcnt_d  = 16'd1;
               if (hcnt_q < MINHI) begin
                  // Glitch: drop the partial word, next clean bit starts a new one
                  err_d    = 1'b1;
                  bitcnt_d = '0;
               end else begin
                  shreg_d = {shreg_q[22:0], bit_v};
                  if (bitcnt_q == 5'd23) begin
                     data_d   = {shreg_q[22:0], bit_v};
                     valid_d  = 1'b1;
                     pixcnt_d = pixcnt_inc;
                     bitcnt_d = '0;
                  end else begin
                     bitcnt_d = bitcnt_q + 5'd1;
                  end
               end
            end else begin
               hcnt_d = hcnt_inc;
               if (hcnt_inc == LATCH) begin
                  // Stuck high: abandon the frame and wait for a fresh rise
                  err_d    = 1'b1;
                  bitcnt_d = '0;
                  pixcnt_d = '0;
                  state_d  = IDLE;
               end
            end
         end
         LOW: begin
            if (rise) begin
               state_d = HIGH;
               hcnt_d  = 16'd1;
            end else begin
               lcnt_d = lcnt_inc;
               if (lcnt_inc == LATCH) begin
                  latch_d  = 1'b1;
                  flen_d   = pixcnt_q;
                  pixcnt_d = '0;
                  state_d  = IDLE;
                  if (bitcnt_q != 5'd0) begin
                     err_d    = 1'b1;
                     bitcnt_d = '0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.data_o      = data_q;
   assign bus.valid_o     = valid_q;
   assign bus.latch_o     = latch_q;
   assign bus.frame_len_o = flen_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives bit-accurate WS2812 pulses and compares decoded
// words, frame lengths and error pulses against expectations queued per scenario.
module tb_ws2812_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   ws2812_rx_if bus ();

   ws2812_rx dut (
      .clk_sys_i (clk),
      .rst_sys_i (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Expected results, pushed while stimulus is generated
   logic [23:0] exp_words[$];
   logic [15:0] exp_lens[$];
   // Observed results, collected by the monitor
   logic [23:0] obs_words[$];
   logic [15:0] obs_lens[$];
   int          obs_errs  = 0;
   int          obs_coinc = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.valid_o) obs_words.push_back(bus.data_o);
         if (bus.latch_o) obs_lens.push_back(bus.frame_len_o);
         if (bus.err_o) obs_errs++;
         if (bus.latch_o && bus.err_o) obs_coinc++;
      end
   end

   task automatic clear_obs();
      obs_words.delete();
      obs_lens.delete();
      exp_words.delete();
      exp_lens.delete();
      obs_errs  = 0;
      obs_coinc = 0;
   endtask

   task automatic send_pulse(input int h, input int l);
      bus.din_i = 1'b1;
      repeat (h) @(negedge clk);
      bus.din_i = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      if (b) send_pulse(32, 18);
      else   send_pulse(16, 34);
   endtask

   task automatic send_word(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic hold_low(input int n);
      bus.din_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.din_i = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if (bus.data_o !== 24'h0) begin n_fail++; $display("FAIL reset_data got %h want 000000", bus.data_o); end
      n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
      n_checks++; if (bus.latch_o !== 1'b0) begin n_fail++; $display("FAIL reset_latch got %b want 0", bus.latch_o); end
      n_checks++; if (bus.frame_len_o !== 16'h0) begin n_fail++; $display("FAIL reset_flen got %0d want 0", bus.frame_len_o); end
      n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err_o); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_word();
      clear_obs();
      exp_words.push_back(24'hA53C0F);
      exp_lens.push_back(16'd1);
      send_word(24'hA53C0F);
      hold_low(2100);
      n_checks++; if (obs_words.size() != exp_words.size()) begin n_fail++; $display("FAIL single_nvalid got %0d want %0d", obs_words.size(), exp_words.size()); end
      while (exp_words.size() > 0 && obs_words.size() > 0) begin
         logic [23:0] e, o;
         e = exp_words.pop_front(); o = obs_words.pop_front();
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL single_data got %h want %h", o, e); end
      end
      n_checks++; if (obs_lens.size() != 1) begin n_fail++; $display("FAIL single_nlatch got %0d want 1", obs_lens.size()); end
      else begin
         n_checks++; if (obs_lens[0] !== exp_lens[0]) begin n_fail++; $display("FAIL single_flen got %0d want %0d", obs_lens[0], exp_lens[0]); end
      end
      n_checks++; if (obs_errs != 0) begin n_fail++; $display("FAIL single_err got %0d want 0", obs_errs); end
      n_checks++; if (bus.data_o !== 24'hA53C0F) begin n_fail++; $display("FAIL single_hold got %h want a53c0f", bus.data_o); end
   endtask

   task automatic test_threshold();
      clear_obs();
      exp_words.push_back(24'h000001);
      for (int i = 0; i < 22; i++) send_bit(1'b0);
      send_pulse(23, 27);
      send_pulse(24, 26);
      hold_low(2100);
      n_checks++; if (obs_words.size() != 1) begin n_fail++; $display("FAIL thresh_nvalid got %0d want 1", obs_words.size()); end
      else begin
         n_checks++; if (obs_words[0] !== exp_words[0]) begin n_fail++; $display("FAIL thresh_data got %h want %h", obs_words[0], exp_words[0]); end
      end
      n_checks++; if (obs_errs != 0) begin n_fail++; $display("FAIL thresh_err got %0d want 0", obs_errs); end
   endtask

   task automatic test_glitch();
      clear_obs();
      exp_words.push_back(24'hFFFFFF);
      for (int i = 0; i < 10; i++) send_bit(i[0]);
      send_pulse(3, 40);
      send_word(24'hFFFFFF);
      hold_low(2100);
      n_checks++; if (obs_errs != 1) begin n_fail++; $display("FAIL glitch_err got %0d want 1", obs_errs); end
      n_checks++; if (obs_words.size() != 1) begin n_fail++; $display("FAIL glitch_nvalid got %0d want 1", obs_words.size()); end
      else begin
         n_checks++; if (obs_words[0] !== exp_words[0]) begin n_fail++; $display("FAIL glitch_data got %h want %h", obs_words[0], exp_words[0]); end
      end
   endtask

   task automatic test_partial();
      clear_obs();
      exp_lens.push_back(16'd0);
      for (int i = 0; i < 12; i++) send_bit(1'b1);
      hold_low(2100);
      n_checks++; if (obs_words.size() != 0) begin n_fail++; $display("FAIL partial_nvalid got %0d want 0", obs_words.size()); end
      n_checks++; if (obs_lens.size() != 1) begin n_fail++; $display("FAIL partial_nlatch got %0d want 1", obs_lens.size()); end
      else begin
         n_checks++; if (obs_lens[0] !== exp_lens[0]) begin n_fail++; $display("FAIL partial_flen got %0d want %0d", obs_lens[0], exp_lens[0]); end
      end
      n_checks++; if (obs_coinc != 1) begin n_fail++; $display("FAIL partial_latch_err got %0d want 1", obs_coinc); end
      n_checks++; if (obs_errs != 1) begin n_fail++; $display("FAIL partial_err got %0d want 1", obs_errs); end
   endtask

   task automatic test_multi_frame();
      logic [23:0] words[5];
      clear_obs();
      words = '{24'h000001, 24'h800000, 24'h123456, 24'hC0FFEE, 24'h5A5A5A};
      for (int i = 0; i < 3; i++) begin exp_words.push_back(words[i]); send_word(words[i]); end
      exp_lens.push_back(16'd3);
      hold_low(2100);
      for (int i = 3; i < 5; i++) begin exp_words.push_back(words[i]); send_word(words[i]); end
      exp_lens.push_back(16'd2);
      hold_low(2100);
      n_checks++; if (obs_words.size() != exp_words.size()) begin n_fail++; $display("FAIL multi_nvalid got %0d want %0d", obs_words.size(), exp_words.size()); end
      while (exp_words.size() > 0 && obs_words.size() > 0) begin
         logic [23:0] e, o;
         e = exp_words.pop_front(); o = obs_words.pop_front();
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL multi_data got %h want %h", o, e); end
      end
      n_checks++; if (obs_lens.size() != exp_lens.size()) begin n_fail++; $display("FAIL multi_nlatch got %0d want %0d", obs_lens.size(), exp_lens.size()); end
      while (exp_lens.size() > 0 && obs_lens.size() > 0) begin
         logic [15:0] e, o;
         e = exp_lens.pop_front(); o = obs_lens.pop_front();
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL multi_flen got %0d want %0d", o, e); end
      end
      n_checks++; if (obs_errs != 0) begin n_fail++; $display("FAIL multi_err got %0d want 0", obs_errs); end
   endtask

   task automatic test_stuck_high();
      clear_obs();
      bus.din_i = 1'b1;
      repeat (2500) @(negedge clk);
      hold_low(2100);
      n_checks++; if (obs_errs != 1) begin n_fail++; $display("FAIL stuck_err got %0d want 1", obs_errs); end
      n_checks++; if (obs_words.size() != 0) begin n_fail++; $display("FAIL stuck_nvalid got %0d want 0", obs_words.size()); end
      n_checks++; if (obs_lens.size() != 0) begin n_fail++; $display("FAIL stuck_nlatch got %0d want 0", obs_lens.size()); end
   endtask

   task automatic test_reset_mid_word();
      clear_obs();
      for (int i = 0; i < 20; i++) send_bit(1'b1);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.data_o !== 24'h0) begin n_fail++; $display("FAIL rstmid_data got %h want 000000", bus.data_o); end
      n_checks++; if (bus.frame_len_o !== 16'h0) begin n_fail++; $display("FAIL rstmid_flen got %0d want 0", bus.frame_len_o); end
      n_checks++; if ({bus.valid_o, bus.latch_o, bus.err_o} !== 3'b000) begin n_fail++; $display("FAIL rstmid_pulses got %b want 000", {bus.valid_o, bus.latch_o, bus.err_o}); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      exp_words.push_back(24'h00FF00);
      exp_lens.push_back(16'd1);
      send_word(24'h00FF00);
      hold_low(2100);
      n_checks++; if (obs_words.size() != 1) begin n_fail++; $display("FAIL rstmid_nvalid got %0d want 1", obs_words.size()); end
      else begin
         n_checks++; if (obs_words[0] !== exp_words[0]) begin n_fail++; $display("FAIL rstmid_word got %h want %h", obs_words[0], exp_words[0]); end
      end
      n_checks++; if (obs_lens.size() != 1) begin n_fail++; $display("FAIL rstmid_nlatch got %0d want 1", obs_lens.size()); end
      else begin
         n_checks++; if (obs_lens[0] !== exp_lens[0]) begin n_fail++; $display("FAIL rstmid_flen2 got %0d want %0d", obs_lens[0], exp_lens[0]); end
      end
      n_checks++; if (obs_errs != 0) begin n_fail++; $display("FAIL rstmid_err got %0d want 0", obs_errs); end
   endtask

   initial begin
      bus.din_i = 1'b0;
      test_reset();
      test_single_word();
      test_threshold();
      test_glitch();
      test_partial();
      test_multi_frame();
      test_stuck_high();
      test_reset_mid_word();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
